// File: rtl/fifo_ctrl_pkg.sv
// rtl/fifo_ctrl_pkg.sv - shared types and constants for the FIFO burst read controller
package fifo_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BURST = 2'd1,
    DRAIN = 2'd2
  } state_t;

  localparam int OBUF_DEPTH = 4;
  localparam int PTR_W      = 2;
  localparam int OCC_W      = 3;
  localparam int CNT_W      = 9;
  localparam int TMR_W      = 16;
  localparam int FLUSH_W    = 8;
  localparam int DATA_W_DEF = 8;

  function automatic logic [FLUSH_W-1:0] sat_inc(input logic [FLUSH_W-1:0] v);
    return (v == '1) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/fifo_ctrl_obuf.sv
// rtl/fifo_ctrl_obuf.sv - 4-entry {data, last} output buffer with valid/ready head
module fifo_ctrl_obuf
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [DATA_W-1:0] push_data,
  input  logic              push_last,
  output logic [OCC_W-1:0]  occ,
  output logic [DATA_W-1:0] m_data,
  output logic              m_valid,
  output logic              m_last,
  input  logic              m_ready
);

  logic [DATA_W-1:0]     data_mem [OBUF_DEPTH];
  logic [OBUF_DEPTH-1:0] last_mem;
  logic [PTR_W-1:0]      wr_ptr;
  logic [PTR_W-1:0]      rd_ptr;
  logic                  pop;

  assign m_valid = (occ != '0);
  assign pop     = m_valid && m_ready;
  assign m_data  = data_mem[rd_ptr];
  assign m_last  = last_mem[rd_ptr];

  // Entries are cleared on reset so the head reads as zero while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < OBUF_DEPTH; i++) data_mem[i] <= '0;
      last_mem <= '0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      occ      <= '0;
    end else begin
      if (push) begin
        data_mem[wr_ptr] <= push_data;
        last_mem[wr_ptr] <= push_last;
        wr_ptr           <= wr_ptr + 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   occ <= occ + 1'b1;
        2'b01:   occ <= occ - 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/fifo_burst_rd_ctrl.sv
// rtl/fifo_burst_rd_ctrl.sv - FIFO read sequencer issuing threshold and timeout flush bursts
module fifo_burst_rd_ctrl
  import fifo_ctrl_pkg::*;
#(
  parameter int DATA_W    = 8,
  parameter int LVL_W     = 9,
  parameter int BURST_LEN = 16,
  parameter int TIMEOUT   = 255
) (
  input  logic               sys_clk,
  input  logic               rst_n,
  input  logic [LVL_W-1:0]   fifo_rd_water_level,
  input  logic               fifo_rd_empty,
  input  logic [DATA_W-1:0]  fifo_rd_data,
  output logic               fifo_rd_en,
  output logic [DATA_W-1:0]  m_data,
  output logic               m_valid,
  output logic               m_last,
  input  logic               m_ready,
  output logic               busy,
  output logic [FLUSH_W-1:0] flush_cnt
);

  localparam logic [LVL_W-1:0] BURST_LVL = LVL_W'(BURST_LEN);
  localparam logic [TMR_W-1:0] TMR_LAST  = TMR_W'(TIMEOUT - 1);

  state_t           state;
  logic [CNT_W-1:0] len;
  logic [CNT_W-1:0] issued;
  logic [CNT_W-1:0] beat;
  logic             inflight;
  logic [TMR_W-1:0] idle_tmr;
  logic [OCC_W-1:0] occ;
  logic             lvl_full;
  logic             lvl_some;
  logic             credit_ok;
  logic             push_last;

  assign lvl_full  = (fifo_rd_water_level >= BURST_LVL);
  assign lvl_some  = (fifo_rd_water_level != '0);
  // A read may only issue if its beat is guaranteed a buffer slot on return.
  assign credit_ok = (({1'b0, occ} + 4'(inflight)) < 4'(OBUF_DEPTH));
  assign fifo_rd_en = (state == BURST) && (issued < len) && !fifo_rd_empty && credit_ok;
  assign push_last  = (beat == len - 1'b1);

  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      busy      <= 1'b0;
      len       <= '0;
      issued    <= '0;
      beat      <= '0;
      inflight  <= 1'b0;
      idle_tmr  <= '0;
      flush_cnt <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (fifo_rd_en) issued <= issued + 1'b1;
      if (inflight)   beat   <= beat + 1'b1;
      case (state)
        IDLE: begin
          if (lvl_full) begin
            state    <= BURST;
            busy     <= 1'b1;
            len      <= CNT_W'(BURST_LEN);
            issued   <= '0;
            beat     <= '0;
            idle_tmr <= '0;
          end else if (lvl_some && idle_tmr == TMR_LAST) begin
            state     <= BURST;
            busy      <= 1'b1;
            len       <= CNT_W'(fifo_rd_water_level);
            issued    <= '0;
            beat      <= '0;
            idle_tmr  <= '0;
            flush_cnt <= sat_inc(flush_cnt);
          end else if (lvl_some) begin
            idle_tmr <= idle_tmr + 1'b1;
          end else begin
            idle_tmr <= '0;
          end
        end
        BURST: begin
          if (issued == len) state <= DRAIN;
        end
        DRAIN: begin
          if (m_valid && m_ready && m_last) begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

  fifo_ctrl_obuf #(
    .DATA_W(DATA_W)
  ) u_obuf (
    .clk       (sys_clk),
    .rst_n     (rst_n),
    .push      (inflight),
    .push_data (fifo_rd_data),
    .push_last (push_last),
    .occ       (occ),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_last    (m_last),
    .m_ready   (m_ready)
  );

endmodule

// File: tb/tb_fifo_burst_rd_ctrl.sv
// tb/tb_fifo_burst_rd_ctrl.sv - directed self-checking bench for fifo_burst_rd_ctrl
module tb_fifo_burst_rd_ctrl;

  localparam int TIMEOUT = 255;

  logic       sys_clk = 1'b0;
  logic       rst_n;
  logic [8:0] fifo_rd_water_level;
  logic       fifo_rd_empty;
  logic [7:0] fifo_rd_data;
  logic       fifo_rd_en;
  logic [7:0] m_data;
  logic       m_valid;
  logic       m_last;
  logic       m_ready;
  logic       busy;
  logic [7:0] flush_cnt;

  fifo_burst_rd_ctrl #(
    .DATA_W(8), .LVL_W(9), .BURST_LEN(16), .TIMEOUT(TIMEOUT)
  ) dut (
    .sys_clk             (sys_clk),
    .rst_n               (rst_n),
    .fifo_rd_water_level (fifo_rd_water_level),
    .fifo_rd_empty       (fifo_rd_empty),
    .fifo_rd_data        (fifo_rd_data),
    .fifo_rd_en          (fifo_rd_en),
    .m_data              (m_data),
    .m_valid             (m_valid),
    .m_last              (m_last),
    .m_ready             (m_ready),
    .busy                (busy),
    .flush_cnt           (flush_cnt)
  );

  always #5 sys_clk = ~sys_clk;

  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  // Behavioural source FIFO sharing rst_n with the DUT.
  logic [7:0] fmem [256];
  logic [7:0] f_wr_ptr, f_rd_ptr;
  logic [8:0] f_count;
  logic       wr_en, force_empty;
  logic [7:0] wr_data;

  assign fifo_rd_water_level = f_count;
  assign fifo_rd_empty       = (f_count == 9'd0) || force_empty;

  always @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      f_wr_ptr     <= 8'd0;
      f_rd_ptr     <= 8'd0;
      f_count      <= 9'd0;
      fifo_rd_data <= 8'd0;
    end else begin
      if (wr_en) begin
        fmem[f_wr_ptr] <= wr_data;
        f_wr_ptr       <= f_wr_ptr + 8'd1;
      end
      if (fifo_rd_en) begin
        fifo_rd_data <= fmem[f_rd_ptr];
        f_rd_ptr     <= f_rd_ptr + 8'd1;
      end
      f_count <= f_count + 9'(wr_en) - 9'(fifo_rd_en);
    end
  end

  // Stream monitor: sampled late in each cycle, just before the committing edge.
  logic [7:0] bq [$];
  logic       lq [$];
  int         cq [$];
  int         rq [$];
  int         stab_err = 0, credit_err = 0, empty_err = 0, outstanding = 0;
  logic       prev_stall = 1'b0, prev_last = 1'b0;
  logic [7:0] prev_data = 8'd0;

  always begin
    @(negedge sys_clk);
    #3;
    if (!rst_n) begin
      prev_stall  = 1'b0;
      outstanding = 0;
    end else begin
      if (prev_stall && (!m_valid || m_data !== prev_data || m_last !== prev_last)) stab_err++;
      if (fifo_rd_en && fifo_rd_empty) empty_err++;
      if (fifo_rd_en) rq.push_back(cyc);
      if (m_valid && m_ready) begin
        bq.push_back(m_data);
        lq.push_back(m_last);
        cq.push_back(cyc);
      end
      outstanding = outstanding + int'(fifo_rd_en) - int'(m_valid && m_ready);
      if (outstanding > 4) credit_err++;
      prev_stall = m_valid && !m_ready;
      prev_data  = m_data;
      prev_last  = m_last;
    end
  end

  int   vectors = 0, miscompares = 0;
  logic toggle = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(negedge sys_clk);
    if (toggle) m_ready = ~m_ready;
  endtask

  task automatic write_bytes(input logic [7:0] first, input int n, output int c0);
    c0 = 0;
    for (int i = 0; i < n; i++) begin
      step();
      if (i == 0) c0 = cyc;
      wr_en   = 1'b1;
      wr_data = first + 8'(i);
    end
    step();
    wr_en = 1'b0;
  endtask

  task automatic wait_beats(input int target, input int budget, input string tag);
    int n = 0;
    while (bq.size() < target && n < budget) begin
      step();
      n++;
    end
    chk(tag, 32'(bq.size()), 32'(target));
  endtask

  task automatic check_seq(input int base, input int n, input logic [7:0] first,
                           input int bl, input string tag);
    for (int i = 0; i < n; i++) begin
      logic [31:0] d, l;
      d = (base + i < bq.size()) ? 32'(bq[base+i]) : 32'hDEAD_BEEF;
      l = (base + i < lq.size()) ? 32'(lq[base+i]) : 32'hDEAD_BEEF;
      chk($sformatf("%s_data%0d", tag, i), d, 32'(first + 8'(i)));
      chk($sformatf("%s_last%0d", tag, i), l, 32'(((i + 1) % bl) == 0));
    end
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_rd_en"},  32'(fifo_rd_en), 32'd0);
    chk({tag, "_valid"},  32'(m_valid),    32'd0);
    chk({tag, "_last"},   32'(m_last),     32'd0);
    chk({tag, "_data"},   32'(m_data),     32'd0);
    chk({tag, "_busy"},   32'(busy),       32'd0);
    chk({tag, "_flush"},  32'(flush_cnt),  32'd0);
  endtask

  initial begin
    int base, rbase, c0, n_cyc, m0, guard;
    rst_n = 1'b0; wr_en = 1'b0; wr_data = 8'd0; force_empty = 1'b0; m_ready = 1'b1;
    repeat (3) @(negedge sys_clk);
    #1;
    chk_outputs_zero("rst");
    rst_n = 1'b1;
    repeat (5) step();
    chk("idle_busy", 32'(busy), 32'd0);

    // Full burst with the consumer always ready
    base = bq.size(); rbase = rq.size();
    write_bytes(8'h00, 16, c0);
    n_cyc = cyc;
    chk("fb_pre_busy", 32'(busy), 32'd0);
    chk("fb_pre_rden", 32'(fifo_rd_en), 32'd0);
    step();
    chk("fb_busy", 32'(busy), 32'd1);
    chk("fb_rden", 32'(fifo_rd_en), 32'd1);
    wait_beats(base + 16, 100, "fb_beats");
    check_seq(base, 16, 8'h00, 16, "fb");
    chk("fb_first_cyc", 32'(cq[base]), 32'(n_cyc + 3));
    chk("fb_last_cyc", 32'(cq[base+15]), 32'(n_cyc + 18));
    guard = 0;
    while (cyc < n_cyc + 19 && guard < 50) begin step(); guard++; end
    chk("fb_idle_after", 32'(busy), 32'd0);
    chk("fb_rd_cnt", 32'(rq.size() - rbase), 32'd16);

    // Backpressure: two bursts with m_ready toggling every cycle
    base = bq.size(); rbase = rq.size();
    toggle = 1'b1;
    write_bytes(8'h20, 32, c0);
    wait_beats(base + 32, 400, "bp_beats");
    toggle = 1'b0; m_ready = 1'b1;
    check_seq(base, 32, 8'h20, 16, "bp");
    chk("bp_stable", 32'(stab_err), 32'd0);
    chk("bp_credit", 32'(credit_err), 32'd0);
    repeat (3) step();
    chk("bp_idle", 32'(busy), 32'd0);
    chk("bp_rd_cnt", 32'(rq.size() - rbase), 32'd32);

    // Timeout flush of a 5-byte residue
    base = bq.size();
    write_bytes(8'h50, 5, c0);
    m0 = c0 + 1;
    guard = 0;
    while (cyc < m0 + TIMEOUT - 1 && guard < 600) begin step(); guard++; end
    chk("fl_pre_busy", 32'(busy), 32'd0);
    chk("fl_pre_cnt", 32'(flush_cnt), 32'd0);
    step();
    chk("fl_busy", 32'(busy), 32'd1);
    chk("fl_cnt", 32'(flush_cnt), 32'd1);
    chk("fl_rden", 32'(fifo_rd_en), 32'd1);
    wait_beats(base + 5, 50, "fl_beats");
    check_seq(base, 5, 8'h50, 5, "fl");

    // Level parked just under threshold, then topped up
    base = bq.size(); rbase = rq.size();
    write_bytes(8'h60, 15, c0);
    repeat (100) step();
    chk("th_no_rd", 32'(rq.size() - rbase), 32'd0);
    chk("th_idle", 32'(busy), 32'd0);
    write_bytes(8'h6F, 1, c0);
    wait_beats(base + 16, 100, "th_beats");
    check_seq(base, 16, 8'h60, 16, "th");
    chk("th_flush_cnt", 32'(flush_cnt), 32'd1);

    // Empty flag forced mid-burst
    base = bq.size(); rbase = rq.size();
    write_bytes(8'h70, 16, c0);
    repeat (4) step();
    #1;
    chk("es_rden_before", 32'(fifo_rd_en), 32'd1);
    for (int k = 0; k < 3; k++) begin
      step();
      force_empty = 1'b1;
      #1;
      chk($sformatf("es_rden_stall%0d", k), 32'(fifo_rd_en), 32'd0);
    end
    step();
    force_empty = 1'b0;
    wait_beats(base + 16, 100, "es_beats");
    check_seq(base, 16, 8'h70, 16, "es");
    chk("es_empty_reads", 32'(empty_err), 32'd0);
    chk("es_rd_cnt", 32'(rq.size() - rbase), 32'd16);

    // Reset halfway through a burst
    base = bq.size();
    write_bytes(8'h80, 16, c0);
    wait_beats(base + 8, 100, "mr_beats");
    rst_n = 1'b0;
    #1;
    chk_outputs_zero("mr");
    step(); step();
    rst_n = 1'b1;
    rbase = rq.size();
    repeat (20) step();
    chk("mr_busy", 32'(busy), 32'd0);
    chk("mr_level", 32'(fifo_rd_water_level), 32'd0);
    chk("mr_no_rd", 32'(rq.size() - rbase), 32'd0);
    chk("mr_no_beats", 32'(bq.size()), 32'(base + 8));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: observed no completion, expected finish before time limit");
    $fatal(1, "watchdog");
  end

endmodule
